// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
//
// Reads a burst of consecutive words from a RAM with an asynchronous
// (combinational) read port and presents them as a valid/ready stream.
// The RAM address wraps modulo 2**ADDR_WIDTH. A zero-length request only
// produces a done pulse.
//
// Optional feature: define RAM_RDR_LAST_EN to add a registered out_last
// flag that marks the final beat of each burst.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   start       burst request, sampled only while idle
//   start_addr  first RAM word of the burst
//   length      beat count, 0..2**ADDR_WIDTH
//   busy        high while a burst is in progress
//   done        one-cycle pulse after the final handshake of a burst
//   ram_addr    read address to the RAM
//   ram_data    combinational read data for ram_addr
//   out_valid   out_data holds a beat
//   out_ready   downstream accepts the beat
//   out_data    registered stream data
//   out_last    final-beat flag (RAM_RDR_LAST_EN only)
// ---------------------------------------------------------------------------
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef RAM_RDR_LAST_EN
    ,
    output logic                  out_last
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]          state;
    logic [ADDR_WIDTH:0] remaining;
    logic                load;

    // The output register can take a new word when it is empty or when its
    // current beat is being accepted this cycle.
    assign load = !out_valid || out_ready;
    assign busy = (state != ST_IDLE);

    // NOTE: every register here uses non-blocking assignment so all updates
    // see the pre-edge values; the reset branch is asynchronous, so it is in
    // the sensitivity list rather than tested only on clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ram_addr  <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
`ifdef RAM_RDR_LAST_EN
            out_last  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            ram_addr  <= start_addr;
                            remaining <= length;
                            state     <= ST_READ;
                        end else begin
                            // Empty burst: acknowledge immediately, never go busy.
                            done <= 1'b1;
                        end
                    end
                end

                ST_READ: begin
                    // In READ a handshake always coincides with a load, so
                    // out_valid simply stays set across back-to-back beats.
                    if (load) begin
                        out_data  <= ram_data;
                        out_valid <= 1'b1;
                        ram_addr  <= ram_addr + ADDR_ONE;
                        remaining <= remaining - LEN_ONE;
`ifdef RAM_RDR_LAST_EN
                        out_last  <= (remaining == LEN_ONE);
`endif
                        if (remaining == LEN_ONE) begin
                            state <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    // The final beat sits in the output register until taken.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
`ifdef RAM_RDR_LAST_EN
                        out_last  <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_stream_reader
//
// Directed bench for ram_stream_reader (ADDR_WIDTH=4, DATA_WIDTH=8). A RAM
// holding 8'h10+index feeds the reader. A reference model keeps a queue of
// the beats each accepted burst must deliver and checks the stream, busy,
// done, latency, throughput and stall stability on every falling edge;
// literal expectations per scenario pin the model.
// ---------------------------------------------------------------------------
module tb_ram_stream_reader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic [DW-1:0] mem [DEPTH];

    assign ram_data = mem[ram_addr];

`ifndef RAM_RDR_LAST_EN
    assign out_last = 1'b0;
`endif

    ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef RAM_RDR_LAST_EN
        ,
        .out_last   (out_last)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model + compare (falling edge) -------------
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got [$];
    logic          got_last [$];
    bit            m_busy       = 1'b0;
    bit            done_pending = 1'b0;
    int            first_wait   = 0;
    bit            prev_stall   = 1'b0;
    bit            prev_hs      = 1'b0;
    logic [DW-1:0] prev_data    = '0;
    int            done_cnt     = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_busy       = 1'b0;
            done_pending = 1'b0;
            first_wait   = 0;
            prev_stall   = 1'b0;
            prev_hs      = 1'b0;
        end else begin
            check("busy", busy, m_busy);
            check("done", done, done_pending);
            if (done) done_cnt++;
            if (first_wait == 2) check("latency_not_yet_valid", out_valid, 0);
            else if (first_wait == 1) check("latency_first_beat_valid", out_valid, 1);
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, prev_data);
            end
            if (prev_hs && exp_q.size() > 0) check("throughput_valid", out_valid, 1);
            if (out_valid) begin
                if (exp_q.size() == 0) check("spurious_beat", out_valid, 0);
                else begin
                    check("beat_data", out_data, exp_q[0]);
`ifdef RAM_RDR_LAST_EN
                    check("out_last", out_last, exp_q.size() == 1);
`endif
                end
            end else begin
`ifdef RAM_RDR_LAST_EN
                check("out_last_idle", out_last, 0);
`endif
            end

            // Advance the model across the coming rising edge.
            done_pending = 1'b0;
            if (first_wait > 0) first_wait--;
            prev_stall = out_valid && !out_ready;
            prev_hs    = out_valid && out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                got_last.push_back(out_last);
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_busy       = 1'b0;
                        done_pending = 1'b1;
                    end
                end
            end
            if (start && !m_busy) begin
                if (length == 0) done_pending = 1'b1;
                else begin
                    for (int i = 0; i < int'(length); i++)
                        exp_q.push_back(mem[(int'(start_addr) + i) % DEPTH]);
                    m_busy     = 1'b1;
                    first_wait = 2;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------------------------------
    logic [DW-1:0] e [4];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [AW:0] n);
        start_addr = a;
        length     = n;
        start      = 1'b1;
        cycle();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            n++;
            if (done) return;
        end
        check("wait_done_timeout", done, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (!busy) break;
        end
        check("wait_idle_timeout", busy, 0);
        cycle();
    endtask

    task automatic check_got(input string name, input int n);
        check({name, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            check(name, got[i], e[i]);
    endtask

    // ---------------- stimulus ----------------------------------------------
    int n_cyc;
    int d0;
    logic [5:0] rpat;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h10 + DW'(i);
        rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;
        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_out_last", out_last, 0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Basic burst: 12,13,14,15; start edge N, done visible after N+5.
        got.delete(); got_last.delete();
        issue(4'd2, 5'd4);
        wait_done(20, n_cyc);
        check("s1_cycles_to_done", n_cyc, 5);
        cycle();
        e = '{8'h12, 8'h13, 8'h14, 8'h15};
        check_got("s1_beat", 4);

        // Address wrap: 1E,1F,10,11.
        got.delete(); got_last.delete();
        issue(4'd14, 5'd4);
        wait_done(20, n_cyc);
        check("s2_cycles_to_done", n_cyc, 5);
        cycle();
        e = '{8'h1E, 8'h1F, 8'h10, 8'h11};
        check_got("s2_beat", 4);

        // Backpressure: ready 1,0,0,1,0,1 once the first beat is showing.
        got.delete(); got_last.delete();
        d0 = done_cnt;
        issue(4'd0, 5'd3);
        cycle();
        rpat = 6'b101001;  // bit i is the ready value for step i
        for (int i = 0; i < 6; i++) begin
            out_ready = rpat[i];
            cycle();
        end
        out_ready = 1'b1;
        wait_idle(20);
        check("s3_done_pulses", done_cnt - d0, 1);
        e = '{8'h10, 8'h11, 8'h12, 8'h00};
        check_got("s3_beat", 3);

        // Zero-length request: done for one cycle, never busy, no beat.
        got.delete(); got_last.delete();
        d0 = done_cnt;
        issue(4'd7, 5'd0);
        check("s4_done_high", done, 1);
        check("s4_busy_low", busy, 0);
        check("s4_no_valid", out_valid, 0);
        cycle();
        check("s4_done_cleared", done, 0);
        cycle();
        check("s4_done_pulses", done_cnt - d0, 1);
        check("s4_no_beats", got.size(), 0);

        // Reset mid-burst after the third beat, then a fresh burst.
        got.delete(); got_last.delete();
        d0 = done_cnt;
        issue(4'd5, 5'd16);
        for (int i = 0; i < 30 && got.size() < 3; i++) cycle();
        check("s5_three_beats_seen", got.size(), 3);
        #2 rst = 1'b1;
        #1;
        check("s5_rst_busy", busy, 0);
        check("s5_rst_done", done, 0);
        check("s5_rst_out_valid", out_valid, 0);
        check("s5_rst_out_data", out_data, 0);
        check("s5_rst_ram_addr", ram_addr, 0);
        check("s5_rst_out_last", out_last, 0);
        cycle();
        rst = 1'b0;
        repeat (4) cycle();
        check("s5_no_done_after_abort", done_cnt - d0, 0);
        e = '{8'h15, 8'h16, 8'h17, 8'h00};
        check_got("s5_beat", 3);
        got.delete(); got_last.delete();
        issue(4'd0, 5'd2);
        wait_done(20, n_cyc);
        check("s5b_cycles_to_done", n_cyc, 3);
        cycle();
        e = '{8'h10, 8'h11, 8'h00, 8'h00};
        check_got("s5b_beat", 2);

        // Two-beat burst with a start pulsed while busy (must be ignored).
        got.delete(); got_last.delete();
        d0 = done_cnt;
        issue(4'd8, 5'd2);
        issue(4'd0, 5'd5);
        wait_idle(20);
        repeat (3) cycle();
        check("s6_done_pulses", done_cnt - d0, 1);
        e = '{8'h18, 8'h19, 8'h00, 8'h00};
        check_got("s6_beat", 2);
`ifdef RAM_RDR_LAST_EN
        if (got_last.size() == 2) begin
            check("s6_last_beat0", got_last[0], 0);
            check("s6_last_beat1", got_last[1], 1);
        end else check("s6_last_count", got_last.size(), 2);
`endif

        check("all_beats_delivered", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
